// File: rtl/jk_excite_driver_if.sv
// Handshake and JK-bank signal bundle for jk_excite_driver.
// master: the requester and bank side. slave: the driver.
interface jk_excite_driver_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       retry_cnt;

  modport master (
    output in_valid,
    output in_data,
    output q_fb,
    input  in_ready,
    input  j_out,
    input  k_out,
    input  busy,
    input  done,
    input  err,
    input  retry_cnt
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  q_fb,
    output in_ready,
    output j_out,
    output k_out,
    output busy,
    output done,
    output err,
    output retry_cnt
  );

endinterface

// File: rtl/jk_excite_driver.sv
// Drives an external JK flip-flop bank to a target word, checking the fed-back Q and
// re-driving up to MAX_RETRY times. Define JK_TOGGLE_OPT_EN for toggle (J=K=1) coding.
module jk_excite_driver #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_RETRY = 3
) (
  input logic              clk,
  input logic              reset,
  jk_excite_driver_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StCheck
  } state_e;

  // retry_cnt is a 2-bit port, so larger limits cannot be reported
  if (MAX_RETRY > 3) begin : g_bad_retry
    $error("MAX_RETRY must fit in the 2-bit retry_cnt port");
  end

  localparam logic [1:0] MaxRetryL = 2'(MAX_RETRY);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] w_target_next;
  logic [1:0]       r_retry;
  logic [1:0]       w_retry_next;
  logic             r_done;
  logic             w_done_next;
  logic             r_err;
  logic             w_err_next;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_match;

  assign w_match = (bus.q_fb == r_target);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_target <= '0;
      r_retry  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_target <= w_target_next;
      r_retry  <= w_retry_next;
      r_done   <= w_done_next;
      r_err    <= w_err_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_target_next = r_target;
    w_retry_next  = r_retry;
    w_done_next   = 1'b0;
    w_err_next    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.in_valid) begin
          w_target_next = bus.in_data;
          w_retry_next  = '0;
          w_state_next  = StDrive;
        end
      end
      StDrive: begin
        w_state_next = StCheck;
      end
      StCheck: begin
        if (w_match) begin
          w_state_next = StIdle;
          w_done_next  = 1'b1;
        end else if (r_retry < MaxRetryL) begin
          w_retry_next = r_retry + 2'd1;
          w_state_next = StDrive;
        end else begin
          w_state_next = StIdle;
          w_err_next   = 1'b1;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Excitation is only presented during DRIVE; zeros elsewhere make the bank hold.
  always_comb begin
    w_j = '0;
    w_k = '0;
    if (r_state == StDrive) begin
`ifdef JK_TOGGLE_OPT_EN
      w_j = r_target ^ bus.q_fb;
      w_k = r_target ^ bus.q_fb;
`else
      w_j = r_target & ~bus.q_fb;
      w_k = ~r_target & bus.q_fb;
`endif
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.busy      = (r_state != StIdle);
  assign bus.j_out     = w_j;
  assign bus.k_out     = w_k;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.retry_cnt = r_retry;

  a_done_err_excl: assert property (@(posedge clk) !(r_done && r_err));
`ifndef JK_TOGGLE_OPT_EN
  a_no_toggle: assert property (@(posedge clk) (w_j & w_k) == '0);
`endif

endmodule

// File: tb/tb_jk_excite_driver.sv
// Self-checking bench for jk_excite_driver with an ideal JK bank model (optional stuck-at-0 bits).
module tb_jk_excite_driver;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_RETRY = 3;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  jk_excite_driver_if #(.WIDTH(WIDTH)) bus ();

  jk_excite_driver #(
    .WIDTH    (WIDTH),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Ideal JK bank: Q' = J&~Q | ~K&Q, with stuck bits forced to 0.
  logic [7:0] bank_q;
  logic [7:0] bank_stuck = 8'h00;
  logic       bank_load  = 1'b1;
  logic [7:0] bank_load_val = 8'h00;

  always @(posedge clk) begin
    if (bank_load) bank_q <= bank_load_val & ~bank_stuck;
    else bank_q <= ((bus.j_out & ~bank_q) | (~bus.k_out & bank_q)) & ~bank_stuck;
  end

  assign bus.q_fb = bank_q;

  typedef struct {
    string      name;
    logic [7:0] q_init;
    logic [7:0] target;
    logic [7:0] stuck;
    logic [7:0] exp_j;
    logic [7:0] exp_k;
    bit         exp_ok;
    logic [1:0] exp_retry;
    logic [7:0] exp_q;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Excitation table as stated for each build.
  function automatic logic [7:0] exc_j(input logic [7:0] tgt, input logic [7:0] q);
`ifdef JK_TOGGLE_OPT_EN
    return tgt ^ q;
`else
    return tgt & ~q;
`endif
  endfunction

  function automatic logic [7:0] exc_k(input logic [7:0] tgt, input logic [7:0] q);
`ifdef JK_TOGGLE_OPT_EN
    return tgt ^ q;
`else
    return ~tgt & q;
`endif
  endfunction

  task automatic preload(input logic [7:0] q, input logic [7:0] stuck);
    @(negedge clk);
    bank_stuck    = stuck;
    bank_load_val = q;
    bank_load     = 1'b1;
    @(negedge clk);
    bank_load     = 1'b0;
  endtask

  // Leaves the bench at a negedge with the DUT back in IDLE.
  task automatic run_txn(input vec_t v);
    int   end_cyc;
    bit   seen_end;
    bit   clean;
    preload(v.q_init, v.stuck);
    end_cyc = v.exp_ok ? 3 : 3 + 2 * MAX_RETRY;
    chk({v.name, " ready_before"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = v.target;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    chk({v.name, " drive_j"}, bus.j_out, v.exp_j);
    chk({v.name, " drive_k"}, bus.k_out, v.exp_k);
    chk({v.name, " drive_busy_notready"}, {bus.busy, bus.in_ready}, 2'b10);
    seen_end = 0;
    clean    = 1;
    for (int c = 1; c <= 20 && !seen_end; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.done || bus.err) begin
        seen_end = 1;
        chk({v.name, " latency"}, c, end_cyc);
        chk({v.name, " done_err"}, {bus.done, bus.err}, {v.exp_ok, !v.exp_ok});
        chk({v.name, " retry_cnt"}, bus.retry_cnt, v.exp_retry);
        chk({v.name, " idle_at_end"}, {bus.busy, bus.in_ready, bus.j_out, bus.k_out},
            {2'b01, 16'h0000});
      end else if ((c % 2) == 0 && (bus.j_out | bus.k_out) != 8'h00) begin
        clean = 0;
      end
    end
    chk({v.name, " finished_in_budget"}, seen_end, 1);
    chk({v.name, " hold_outside_drive"}, clean, 1);
    @(negedge clk);
    chk({v.name, " pulse_one_cycle"}, {bus.done, bus.err}, 2'b00);
    chk({v.name, " retry_held"}, bus.retry_cnt, v.exp_retry);
    chk({v.name, " bank_q"}, bank_q, v.exp_q);
  endtask

  function automatic vec_t model(input string nm, input logic [7:0] q0, input logic [7:0] tgt,
                                 input logic [7:0] stuck);
    vec_t v;
    v.name      = nm;
    v.q_init    = q0 & ~stuck;
    v.target    = tgt;
    v.stuck     = stuck;
    v.exp_j     = exc_j(tgt, v.q_init);
    v.exp_k     = exc_k(tgt, v.q_init);
    v.exp_ok    = ((tgt & stuck) == 8'h00);
    v.exp_retry = v.exp_ok ? 2'd0 : 2'(MAX_RETRY);
    v.exp_q     = tgt & ~stuck;
    return v;
  endfunction

  vec_t table_v[4];

  initial begin
`ifdef JK_TOGGLE_OPT_EN
    table_v[0] = '{"a5_from_00", 8'h00, 8'hA5, 8'h00, 8'hA5, 8'hA5, 1'b1, 2'd0, 8'hA5};
    table_v[1] = '{"5a_from_a5", 8'hA5, 8'h5A, 8'h00, 8'hFF, 8'hFF, 1'b1, 2'd0, 8'h5A};
    table_v[3] = '{"stuck_bit0", 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 1'b0, 2'd3, 8'h00};
`else
    table_v[0] = '{"a5_from_00", 8'h00, 8'hA5, 8'h00, 8'hA5, 8'h00, 1'b1, 2'd0, 8'hA5};
    table_v[1] = '{"5a_from_a5", 8'hA5, 8'h5A, 8'h00, 8'h5A, 8'hA5, 1'b1, 2'd0, 8'h5A};
    table_v[3] = '{"stuck_bit0", 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 1'b0, 2'd3, 8'h00};
`endif
    table_v[2] = '{"equal_3c", 8'h3C, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b1, 2'd0, 8'h3C};

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {bus.in_ready, bus.busy, bus.done, bus.err, bus.retry_cnt},
        {1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
    chk("reset_jk", {bus.j_out, bus.k_out}, 16'h0000);
    reset     = 1'b0;
    bank_load = 1'b0;

    foreach (table_v[i]) run_txn(table_v[i]);

    // Reset during CHECK of a 0xFF transaction aborts with no pulse.
    preload(8'h00, 8'h00);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_check_busy", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_state", {bus.in_ready, bus.busy, bus.done, bus.err, bus.retry_cnt},
        {1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
    chk("abort_jk", {bus.j_out, bus.k_out}, 16'h0000);
    begin
      bit pulsed = 0;
      repeat (5) begin
        @(negedge clk);
        if (bus.done || bus.err || bus.busy) pulsed = 1;
      end
      chk("abort_no_pulse", pulsed, 0);
    end

    // Reset wins over a simultaneous accept.
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    chk("reset_priority_idle", {bus.busy, bus.in_ready}, 2'b01);
    @(negedge clk);
    chk("reset_priority_no_accept", bus.busy, 0);

    // Back-to-back: 0x22 must wait until the done cycle of 0x11.
    preload(8'h00, 8'h00);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    @(negedge clk);
    bus.in_data = 8'h22;
    chk("b2b_first_drive_j", bus.j_out, exc_j(8'h11, 8'h00));
    chk("b2b_c1_not_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("b2b_c2_not_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("b2b_done_and_ready", {bus.done, bus.in_ready}, 2'b11);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b_second_busy", bus.busy, 1);
    chk("b2b_second_j", bus.j_out, exc_j(8'h22, 8'h11));
    chk("b2b_second_k", bus.k_out, exc_k(8'h22, 8'h11));
    repeat (2) @(negedge clk);
    chk("b2b_second_done", bus.done, 1);
    chk("b2b_final_q", bank_q, 8'h22);

    // Randomised transactions against the reference model.
    for (int n = 0; n < 30; n++) begin
      logic [7:0] stuck;
      logic [7:0] q0;
      logic [7:0] tgt;
      stuck = ($urandom_range(0, 3) == 0) ? 8'(8'h01 << $urandom_range(0, 7)) : 8'h00;
      q0    = 8'($urandom);
      tgt   = 8'($urandom);
      run_txn(model($sformatf("rand%0d", n), q0, tgt, stuck));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jk_excite_driver.md
JK_EXCITE_DRIVER -- requirements
Module: jk_excite_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of JK flip-flops driven in the external bank.
REQ-002 The block SHALL have parameter MAX_RETRY, default 3, giving the number of re-drive attempts after a failed check.
REQ-003 Port clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port in_valid  input  1  target word offered.
REQ-006 Port in_ready  output  1  block can accept a target word.
REQ-007 Port in_data  input  WIDTH  target Q value for the bank.
REQ-008 Port q_fb  input  WIDTH  Q outputs fed back from the JK bank, which is clocked on the same clk.
REQ-009 Port j_out  output  WIDTH  J inputs to the bank.
REQ-010 Port k_out  output  WIDTH  K inputs to the bank.
REQ-011 Port busy  output  1  transaction in progress.
REQ-012 Port done  output  1  one-cycle pulse: bank matches target.
REQ-013 Port err  output  1  one-cycle pulse: retries exhausted without a match.
REQ-014 Port retry_cnt  output  2  retries used by the current or most recent transaction.

Function
REQ-015 The FSM SHALL have the states IDLE, DRIVE and CHECK, and only those states.
REQ-016 IDLE: in_ready=1, busy=0; an in_valid&&in_ready edge SHALL capture in_data into target, clear retry_cnt and enter DRIVE.
REQ-017 DRIVE (one cycle): j_out/k_out SHALL be combinational from target and q_fb per REQ-024; next state SHALL be CHECK.
REQ-018 CHECK: if q_fb==target, the block SHALL go to IDLE and pulse done on the following cycle.
REQ-019 CHECK mismatch with retry_cnt<MAX_RETRY: the block SHALL increment retry_cnt and go to DRIVE.
REQ-020 CHECK mismatch with retry_cnt==MAX_RETRY: the block SHALL go to IDLE and pulse err on the following cycle.
REQ-021 Outside DRIVE, j_out and k_out SHALL be all zeros, so the bank holds.
REQ-022 in_ready SHALL be 0 in DRIVE and CHECK; in_valid SHALL be ignored there and in_data SHALL NOT be sampled.
REQ-023 Latency: for an accept at edge N with no retries, done SHALL be high in the cycle following edge N+2; each retry SHALL add 2 cycles.
REQ-024 Base excitation, per bit: target=1 and q=0 -> J=1, K=0; target=0 and q=1 -> J=0, K=1; target==q -> J=0, K=0.
REQ-025 done and err SHALL be registered, mutually exclusive, and high for exactly one cycle.
REQ-026 A new accept SHALL be allowed in the same cycle that done or err is high, since the block is in IDLE.
REQ-027 retry_cnt SHALL hold its value in IDLE until the next accept.

Reset
REQ-028 While reset=1 at a clock edge, the FSM SHALL go to IDLE.
REQ-029 The reset values SHALL be: target=0, retry_cnt=0, done=0, err=0, busy=0, j_out=0, k_out=0 and in_ready=1 from the first cycle after reset.
REQ-030 Reset asserted in DRIVE or CHECK SHALL abort the transaction with no done or err pulse.
REQ-031 Reset SHALL take priority over an in_valid accept in the same cycle.

Configuration
REQ-032 Macro JK_TOGGLE_OPT_EN SHALL select the excitation coding for differing bits.
REQ-033 With JK_TOGGLE_OPT_EN defined, every bit where target!=q_fb SHALL be driven J=1, K=1 (toggle), and equal bits J=0, K=0.
REQ-034 Without JK_TOGGLE_OPT_EN, the base table of REQ-024 SHALL apply; J=1, K=1 SHALL never be driven.
REQ-035 FSM timing, handshake and retry behaviour SHALL be identical in both builds.

Verification (WIDTH=8, MAX_RETRY=3, ideal JK bank model)
REQ-036 Reset with bank Q=0x00, then send target 0xA5 -> in the DRIVE cycle j_out=0xA5, k_out=0x00; done pulses 3 cycles after accept; retry_cnt=0.
REQ-037 Bank Q=0xA5, send 0x5A -> base build: j_out=0x5A, k_out=0xA5; toggle build: j_out=k_out=0xFF; done in both builds, Q=0x5A.
REQ-038 Send target equal to the current Q, 0x3C -> j_out=k_out=0x00 in DRIVE; done pulses; Q unchanged.
REQ-039 Bank model with bit 0 stuck at 0, target 0x01 -> 4 DRIVE cycles; err pulses once; retry_cnt=3; done is never high.
REQ-040 Assert reset in the CHECK cycle of a 0xFF transaction -> next cycle IDLE, in_ready=1, j_out=k_out=0, no done or err pulse.
REQ-041 Hold in_valid high with 0x11 then 0x22 back-to-back -> 0x22 SHALL NOT be accepted while busy; 0x22 SHALL be accepted in the done cycle of 0x11; final Q=0x22.
